// File: rtl/noc_out_alloc_pkg.sv
// Shared types and constants for the NOC output-port allocator.
package noc_out_alloc_pkg;

   localparam int unsigned N_PORTS = 4;

   typedef logic [$clog2(N_PORTS)-1:0] port_idx_t;

   typedef enum logic {IDLE, LOCKED} alloc_state_t;

   // Width needed to hold 0..credits inclusive.
   function automatic int unsigned credit_w(input int unsigned credits);
      return $clog2(credits + 1);
   endfunction

endpackage

// File: rtl/noc_out_alloc_if.sv
// Request/grant/credit bundle between the input side and one output allocator.
interface noc_out_alloc_if #(
   parameter int unsigned N_IN    = 4,
   parameter int unsigned CREDITS = 4
) ();
   import noc_out_alloc_pkg::*;

   localparam int unsigned IdxW = $clog2(N_IN);
   localparam int unsigned CntW = credit_w(CREDITS);

   logic [N_IN-1:0] req;
   logic [N_IN-1:0] tail;
   logic            credit_ret;
   logic [N_IN-1:0] grant;
   logic [IdxW-1:0] sel;
   logic            xfer;
   logic [CntW-1:0] credit_cnt;
   logic            credit_err;

   modport master (
      output req, tail, credit_ret,
      input  grant, sel, xfer, credit_cnt, credit_err
   );

   modport slave (
      input  req, tail, credit_ret,
      output grant, sel, xfer, credit_cnt, credit_err
   );

endinterface

// File: rtl/noc_out_alloc_rr_pick.sv
// Combinational rotating-priority picker: index ptr_i has highest priority.
module rr_pick #(
   parameter int unsigned N = 4
) (
   input  logic [N-1:0]         req_i,
   input  logic [$clog2(N)-1:0] ptr_i,
   output logic                 any_o,
   output logic [$clog2(N)-1:0] idx_o,
   output logic [N-1:0]         onehot_o
);
   localparam int unsigned IdxW = $clog2(N);

   logic [N-1:0]    rot;
   logic [IdxW-1:0] lo;
   logic [IdxW-1:0] src;
   logic            found;

   // Rotate right by ptr, take lowest set bit, rotate the index back (wraps mod N).
   always_comb begin
      rot   = '0;
      lo    = '0;
      src   = '0;
      found = 1'b0;
      for (int i = 0; i < N; i++) begin
         src    = IdxW'(i) + ptr_i;
         rot[i] = req_i[src];
      end
      for (int i = 0; i < N; i++) begin
         if (!found && rot[i]) begin
            lo    = IdxW'(i);
            found = 1'b1;
         end
      end
      any_o    = found;
      idx_o    = lo + ptr_i;
      onehot_o = found ? (N'(1) << idx_o) : '0;
   end

endmodule

// File: rtl/noc_out_alloc.sv
// Per-output switch allocator: round-robin grant held for a whole wormhole
// packet, every flit transfer gated on downstream credits.
// Optional build macro NOC_ALLOC_BACK2BACK_EN: re-arbitrate on the tail
// transfer so the next packet is granted with no idle bubble.
module noc_out_alloc
   import noc_out_alloc_pkg::*;
#(
   parameter int unsigned N_IN    = N_PORTS,
   parameter int unsigned CREDITS = 4
) (
   input  logic           clk_i,
   input  logic           reset_ni,
   noc_out_alloc_if.slave bus
);
   localparam int unsigned     IdxW   = $clog2(N_IN);
   localparam int unsigned     CntW   = credit_w(CREDITS);
   localparam logic [CntW-1:0] CntMax = CntW'(CREDITS);

   alloc_state_t    state_q, state_d;
   logic [N_IN-1:0] grant_q, grant_d;
   logic [IdxW-1:0] sel_q, sel_d;
   logic [IdxW-1:0] ptr_q, ptr_d;
   logic [CntW-1:0] credit_q, credit_d;
   logic            err_q, err_d;
   logic [IdxW-1:0] next_ptr;
   logic            xfer;
   logic            tail_xfer;

   logic            pick_any;
   logic [IdxW-1:0] pick_idx;
   logic [N_IN-1:0] pick_oh;

   assign next_ptr = sel_q + IdxW'(1);

   rr_pick #(.N(N_IN)) u_pick (
      .req_i    (bus.req),
      .ptr_i    (ptr_q),
      .any_o    (pick_any),
      .idx_o    (pick_idx),
      .onehot_o (pick_oh)
   );

`ifdef NOC_ALLOC_BACK2BACK_EN
   logic [N_IN-1:0] b2b_req;
   logic            b2b_any;
   logic [IdxW-1:0] b2b_idx;
   logic [N_IN-1:0] b2b_oh;

   // Current owner is masked out so it cannot immediately win again.
   assign b2b_req = bus.req & ~grant_q;

   rr_pick #(.N(N_IN)) u_pick_b2b (
      .req_i    (b2b_req),
      .ptr_i    (next_ptr),
      .any_o    (b2b_any),
      .idx_o    (b2b_idx),
      .onehot_o (b2b_oh)
   );
`endif

   // State, grant, pointer and credit registers.
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state_q  <= IDLE;
         grant_q  <= '0;
         sel_q    <= '0;
         ptr_q    <= '0;
         credit_q <= CntMax;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         grant_q  <= grant_d;
         sel_q    <= sel_d;
         ptr_q    <= ptr_d;
         credit_q <= credit_d;
         err_q    <= err_d;
      end
   end

   // Next-state: lock onto a winner in IDLE, release (or hand over) on tail transfer.
   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      sel_d   = sel_q;
      ptr_d   = ptr_q;
      unique case (state_q)
         IDLE: begin
            if (pick_any) begin
               state_d = LOCKED;
               grant_d = pick_oh;
               sel_d   = pick_idx;
            end
         end
         LOCKED: begin
            if (tail_xfer) begin
               ptr_d = next_ptr;
`ifdef NOC_ALLOC_BACK2BACK_EN
               if (b2b_any) begin
                  grant_d = b2b_oh;
                  sel_d   = b2b_idx;
               end else begin
                  state_d = IDLE;
                  grant_d = '0;
               end
`else
               state_d = IDLE;
               grant_d = '0;
`endif
            end
         end
         default: begin
            state_d = IDLE;
            grant_d = '0;
         end
      endcase
   end

   // Outputs: a flit moves only when locked, the owner presents one, and a credit exists.
   always_comb begin
      xfer           = (state_q == LOCKED) && bus.req[sel_q] && (credit_q != '0);
      tail_xfer      = xfer && bus.tail[sel_q];
      bus.xfer       = xfer;
      bus.grant      = grant_q;
      bus.sel        = sel_q;
      bus.credit_cnt = credit_q;
      bus.credit_err = err_q;
   end

   // Credit counter: saturates at CREDITS, overflow attempt is latched as an error.
   always_comb begin
      credit_d = credit_q;
      err_d    = err_q;
      case ({xfer, bus.credit_ret})
         2'b10: credit_d = credit_q - CntW'(1);
         2'b01: begin
            if (credit_q == CntMax) begin
               err_d = 1'b1;
            end else begin
               credit_d = credit_q + CntW'(1);
            end
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_noc_out_alloc.sv
// Directed bench for noc_out_alloc with hand-computed expectations.
module tb_noc_out_alloc;
   import noc_out_alloc_pkg::*;

   localparam int unsigned NIn  = 4;
   localparam int unsigned Cred = 4;

   logic        clk_i    = 1'b0;
   logic        reset_ni = 1'b0;
   int unsigned n_tests  = 0;
   int unsigned n_fail   = 0;

   noc_out_alloc_if #(.N_IN(NIn), .CREDITS(Cred)) bus ();

   noc_out_alloc #(.N_IN(NIn), .CREDITS(Cred)) dut (
      .clk_i    (clk_i),
      .reset_ni (reset_ni),
      .bus      (bus)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   // Let combinational outputs settle, then check grant and xfer.
   task automatic exp_out(input string tag, input logic [3:0] g, input logic x);
      #1;
      check({tag, ".grant"}, 32'(bus.grant), 32'(g));
      check({tag, ".xfer"}, 32'(bus.xfer), 32'(x));
   endtask

   task automatic do_reset();
      reset_ni       = 1'b0;
      bus.req        = '0;
      bus.tail       = '0;
      bus.credit_ret = 1'b0;
      repeat (2) @(posedge clk_i);
      #1;
      reset_ni = 1'b1;
   endtask

   initial begin
      port_idx_t s_exp;

      // Reset state
      do_reset();
      #1;
      check("rst.grant", 32'(bus.grant), 32'h0);
      check("rst.sel", 32'(bus.sel), 32'h0);
      check("rst.xfer", 32'(bus.xfer), 32'h0);
      check("rst.cnt", 32'(bus.credit_cnt), 32'd4);
      check("rst.err", 32'(bus.credit_err), 32'h0);

      // Round-robin over req=1010 with single-flit packets
      bus.req  = 4'b1010;
      bus.tail = 4'b1111;
      exp_out("rr.idle", 4'b0000, 1'b0);
      step();
      exp_out("rr.g1", 4'b0010, 1'b1);
      s_exp = 2'd1;
      check("rr.sel1", 32'(bus.sel), 32'(s_exp));
      step();
      exp_out("rr.bub1", 4'b0000, 1'b0);
      step();
      exp_out("rr.g3", 4'b1000, 1'b1);
      check("rr.sel3", 32'(bus.sel), 32'd3);
      step();
      exp_out("rr.bub2", 4'b0000, 1'b0);
      step();
      exp_out("rr.g1b", 4'b0010, 1'b1);
      check("rr.cnt", 32'(bus.credit_cnt), 32'd2);

      // Multi-flit packet holds the grant against other requesters
      do_reset();
      bus.req  = 4'b1111;
      bus.tail = 4'b0000;
      exp_out("pk.idle", 4'b0000, 1'b0);
      step();
      exp_out("pk.f1", 4'b0001, 1'b1);
      step();
      exp_out("pk.f2", 4'b0001, 1'b1);
      step();
      bus.tail = 4'b0001;
      exp_out("pk.f3", 4'b0001, 1'b1);
      step();
      bus.tail = 4'b0000;
      exp_out("pk.bub", 4'b0000, 1'b0);
      step();
      exp_out("pk.next", 4'b0010, 1'b1);
      check("pk.cnt", 32'(bus.credit_cnt), 32'd1);

      // Credit exhaustion with a 6-flit packet
      do_reset();
      bus.req = 4'b0001;
      exp_out("cr.idle", 4'b0000, 1'b0);
      step();
      for (int i = 0; i < 4; i++) begin
         exp_out($sformatf("cr.f%0d", i), 4'b0001, 1'b1);
         step();
      end
      exp_out("cr.stall", 4'b0001, 1'b0);
      check("cr.cnt0", 32'(bus.credit_cnt), 32'd0);
      step();
      exp_out("cr.stall2", 4'b0001, 1'b0);
      bus.credit_ret = 1'b1;
      step();
      bus.credit_ret = 1'b0;
      exp_out("cr.f4", 4'b0001, 1'b1);
      step();
      bus.credit_ret = 1'b1;
      exp_out("cr.stall3", 4'b0001, 1'b0);
      step();
      bus.credit_ret = 1'b0;
      bus.tail       = 4'b0001;
      exp_out("cr.f5", 4'b0001, 1'b1);
      step();
      bus.tail = 4'b0000;
      bus.req  = 4'b0000;
      exp_out("cr.done", 4'b0000, 1'b0);
      check("cr.cntend", 32'(bus.credit_cnt), 32'd0);

      // Simultaneous return+xfer, starvation, and overflow error
      do_reset();
      bus.req = 4'b0001;
      step();
      step();
      step();
      #1;
      check("ce.cnt2", 32'(bus.credit_cnt), 32'd2);
      bus.credit_ret = 1'b1;
      exp_out("ce.both", 4'b0001, 1'b1);
      step();
      check("ce.cnt2b", 32'(bus.credit_cnt), 32'd2);
      bus.req = 4'b0000;
      exp_out("ce.starve", 4'b0001, 1'b0);
      step();
      step();
      bus.credit_ret = 1'b0;
      #1;
      check("ce.cnt4", 32'(bus.credit_cnt), 32'd4);
      check("ce.err0", 32'(bus.credit_err), 32'h0);
      bus.credit_ret = 1'b1;
      step();
      bus.credit_ret = 1'b0;
      #1;
      check("ce.sat", 32'(bus.credit_cnt), 32'd4);
      check("ce.err1", 32'(bus.credit_err), 32'h1);
      step();
      step();
      check("ce.sticky", 32'(bus.credit_err), 32'h1);
      do_reset();
      #1;
      check("ce.errclr", 32'(bus.credit_err), 32'h0);

      // Asynchronous reset mid-packet, pointer returns to 0
      bus.req  = 4'b0100;
      bus.tail = 4'b0100;
      step();
      exp_out("ar.p1", 4'b0100, 1'b1);
      step();
      bus.tail = 4'b0000;
      exp_out("ar.bub", 4'b0000, 1'b0);
      step();
      exp_out("ar.f1", 4'b0100, 1'b1);
      step();
      exp_out("ar.f2", 4'b0100, 1'b1);
      step();
      exp_out("ar.f3", 4'b0100, 1'b1);
      check("ar.cnt1", 32'(bus.credit_cnt), 32'd1);
      reset_ni = 1'b0;
      #1;
      check("ar.grant", 32'(bus.grant), 32'h0);
      check("ar.sel", 32'(bus.sel), 32'h0);
      check("ar.cnt", 32'(bus.credit_cnt), 32'd4);
      check("ar.xfer", 32'(bus.xfer), 32'h0);
      step();
      reset_ni = 1'b1;
      bus.req  = 4'b1101;
      exp_out("ar.idle", 4'b0000, 1'b0);
      step();
      exp_out("ar.regrant", 4'b0001, 1'b1);

      // Back-to-back single-flit packets from two inputs
      do_reset();
      bus.req  = 4'b0011;
      bus.tail = 4'b1111;
      step();
      exp_out("bb.g0", 4'b0001, 1'b1);
      step();
`ifdef NOC_ALLOC_BACK2BACK_EN
      exp_out("bb.g1", 4'b0010, 1'b1);
      step();
      exp_out("bb.g2", 4'b0001, 1'b1);
      step();
      exp_out("bb.g3", 4'b0010, 1'b1);
`else
      exp_out("bb.bub1", 4'b0000, 1'b0);
      step();
      exp_out("bb.g1", 4'b0010, 1'b1);
      step();
      exp_out("bb.bub2", 4'b0000, 1'b0);
      step();
      exp_out("bb.g2", 4'b0001, 1'b1);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
